instr_prefetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instr_prefetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_prefetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction prefetch unit.
//   fetch_state_e : fetch sequencer state (IDLE / REQ / DISCARD)
//   fetch_entry_t : one prefetch buffer entry, instruction word tagged with its PC
//   align_pc      : forces an address onto a word boundary
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// PC-tagged instruction buffer. Storage is registered; the head entry is read
// combinationally so the consumer sees it in the cycle after it was written.
//   clk        : clock, all state on rising edge
//   rst_b      : synchronous active-low reset
//   flush      : empties the buffer; wins over push and pop
//   push       : write push_entry at the tail
//   push_entry : entry to write
//   pop        : advance the head (caller only pops when count != 0)
//   head       : entry at the head of the buffer
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers are exactly PTR_W bits wide and DEPTH is a power of two, so the
  // natural overflow of the increment is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Data storage carries no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr] <= push_entry;
    end
  end

  assign head = mem_q[rd_ptr];

endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit
// Fetch front end between the instruction memory port and the core. Keeps the
// fetch PC, issues one word request at a time, and buffers returned words in a
// PC-tagged FIFO drained by the core. A redirect flushes the buffer and squashes
// any fetch still in flight.
//   clk_i          : clock
//   rst_i          : synchronous active-low reset
//   mem_req_o      : fetch request, held until mem_ack_i
//   mem_addr_o     : fetch address, stable while mem_req_o is high
//   mem_ack_i      : response valid (may coincide with the first request cycle)
//   mem_data_i     : instruction word returned with mem_ack_i
//   redirect_i     : one-cycle taken-branch pulse from the core
//   redirect_pc_i  : new fetch target (low two bits ignored)
//   instr_valid_o  : buffer non-empty
//   instr_o        : head instruction
//   instr_pc_o     : PC of head instruction
//   instr_ready_i  : core consumes the head when instr_valid_o is high
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding (buffer has no free slot, or reset)
// REQ     | request outstanding for a live address; ack is pushed
// DISCARD | request outstanding for a squashed address; ack is dropped
module instr_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W + 1)'(DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_addr_next;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] fetch_pc_inc;

  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    count_next;
  logic              push;
  logic              pop;
  logic              slot_free;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign redirect_target = align_pc(redirect_pc_i);
  assign fetch_pc_inc    = fetch_pc + PC_STEP;

  // A redirect drops both the arriving response and the consumer's pop.
  assign push = (state == REQ) && mem_ack_i && !redirect_i;
  assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

  // Occupancy after this edge. A new request is only launched when this is
  // below DEPTH, so every outstanding request already owns a free slot and a
  // push into a full buffer can never happen.
  assign count_next = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
  assign slot_free  = (count_next < DEPTH_CNT);

  assign push_entry = '{pc: req_addr, instr: mem_data_i};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst_b      (rst_i),
    .flush      (redirect_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;

    if (redirect_i) begin
      fetch_pc_next = redirect_target;
      unique case (state)
        IDLE: begin
          state_next    = REQ;
          req_addr_next = redirect_target;
        end
        REQ, DISCARD: begin
          // With no ack the memory still owes us a word for the old address;
          // keep presenting it and throw the answer away when it arrives.
          if (mem_ack_i) begin
            state_next    = REQ;
            req_addr_next = redirect_target;
          end else begin
            state_next = DISCARD;
          end
        end
        default: state_next = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (slot_free) begin
            state_next    = REQ;
            req_addr_next = fetch_pc;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            fetch_pc_next = fetch_pc_inc;
            req_addr_next = fetch_pc_inc;
            state_next    = slot_free ? REQ : IDLE;
          end
        end
        DISCARD: begin
          // The buffer was flushed on entry and nothing is pushed here, so a
          // slot is always free for the restarted fetch.
          if (mem_ack_i) begin
            state_next    = REQ;
            req_addr_next = fetch_pc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign mem_req_o     = (state != IDLE);
  assign mem_addr_o    = req_addr;
  assign instr_valid_o = (count != '0);
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with a scoreboard of expected
// {pc, instr} entries checked whenever the core consumes the head.
module tb_instr_prefetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int n_total    = 0;
  int n_pass     = 0;
  int n_fail     = 0;
  int n_consumed = 0;
  int n_acks     = 0;
  int c0;

  logic mem_auto = 1'b1;
  int   mem_lat  = 0;
  int   wait_cnt = 0;

  fetch_entry_t sb[$];

  instr_prefetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0E};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = mem_word(e.pc);
      sb.push_back(e);
    end
  endtask

  task automatic wait_addr(input logic [31:0] a, input int max_cyc, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (mem_req_o === 1'b1 && mem_addr_o === a) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    chk1(tag, hit, 1'b1);
  endtask

  // Memory model: answers mem_lat cycles after a request appears.
  always @(negedge clk) begin
    if (mem_auto) begin
      mem_data_i = mem_word(mem_addr_o);
      if (mem_req_o === 1'b1 && wait_cnt >= mem_lat) begin
        mem_ack_i = 1'b1;
        wait_cnt  = 0;
        n_acks++;
      end else begin
        mem_ack_i = 1'b0;
        if (mem_req_o === 1'b1) wait_cnt++;
        else wait_cnt = 0;
      end
    end
  end

  // Consumer monitor: every head taken by the core must match the scoreboard.
  always @(negedge clk) begin
    fetch_entry_t e;
    #2;
    if (rst_i && !redirect_i && instr_valid_o === 1'b1 && instr_ready_i) begin
      chk1("sb_pending", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("head_pc", instr_pc_o, e.pc);
        chk("head_instr", instr_o, e.instr);
      end
      n_consumed++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    rst_i         = 1'b0;
    mem_ack_i     = 1'b0;
    mem_data_i    = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;

    // Reset state
    step();
    step();
    chk1("rst_req", mem_req_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk1("rst_valid", instr_valid_o, 1'b0);

    // Zero-wait streaming from RESET_PC
    push_exp(32'h0, 16);
    rst_i         = 1'b1;
    instr_ready_i = 1'b1;
    chk1("rel_idle", mem_req_o, 1'b0);
    step();
    chk1("req_rise", mem_req_o, 1'b1);
    chk("req_addr0", mem_addr_o, 32'h0);
    chk1("no_valid_yet", instr_valid_o, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk1("stream_valid", instr_valid_o, 1'b1);
      step();
    end
    chk("stream_count", 32'(n_consumed), 32'd8);

    // Backpressure: restart at 0 with the core stalled
    instr_ready_i = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0;
    n_acks        = 0;
    step();
    redirect_i = 1'b0;
    sb.delete();
    push_exp(32'h0, 16);
    for (int i = 0; i < 8; i++) step();
    chk("bp_acks", 32'(n_acks), 32'd4);
    chk1("bp_req_low", mem_req_o, 1'b0);
    chk1("bp_valid", instr_valid_o, 1'b1);
    chk("bp_head_pc", instr_pc_o, 32'h0);
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    chk1("bp_req_resume", mem_req_o, 1'b1);
    chk("bp_addr_10", mem_addr_o, 32'h10);
    step();
    chk1("bp_refill_stop", mem_req_o, 1'b0);
    c0 = n_consumed;
    instr_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("bp_drain_count", 32'(n_consumed - c0), 32'd5);

    // Redirect during an outstanding slow fetch
    mem_lat       = 3;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0;
    step();
    redirect_i = 1'b0;
    sb.delete();
    push_exp(32'h0, 2);
    wait_addr(32'h8, 40, "reach_08");
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    redirect_i = 1'b0;
    sb.delete();
    push_exp(32'h40, 16);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("discard_addr", mem_addr_o, 32'h8);
      chk1("discard_req", mem_req_o, 1'b1);
      chk1("discard_novalid", instr_valid_o, 1'b0);
      if (mem_ack_i) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk1("discard_ack_seen", found, 1'b1);
    step();
    chk("redir_addr_40", mem_addr_o, 32'h40);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid_o === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk1("first_valid_40", found, 1'b1);
    chk("first_pc_40", instr_pc_o, 32'h40);

    // Redirect coincident with ack and pop
    mem_lat = 0;
    for (int i = 0; i < 4; i++) step();
    chk("coincident_setup", {29'b0, instr_valid_o, mem_ack_i, mem_req_o}, 32'd7);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    step();
    redirect_i = 1'b0;
    sb.delete();
    push_exp(32'h100, 16);
    chk1("redir_valid_drop", instr_valid_o, 1'b0);
    chk("redir_addr_100", mem_addr_o, 32'h100);
    chk1("redir_req_100", mem_req_o, 1'b1);
    c0 = n_consumed;
    for (int i = 0; i < 4; i++) step();
    chk("redir_100_count", 32'(n_consumed - c0), 32'd3);

    // Boundaries: unaligned target and address wrap
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h43;
    step();
    redirect_i = 1'b0;
    sb.delete();
    push_exp(32'h40, 16);
    chk("align_addr_40", mem_addr_o, 32'h40);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    sb.delete();
    push_exp(32'hFFFF_FFFC, 16);
    chk("wrap_addr_top", mem_addr_o, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr_zero", mem_addr_o, 32'h0);
    step();
    chk("wrap_head_pc", instr_pc_o, 32'h0);

    // Reset while a request is outstanding and two entries are buffered
    mem_lat       = 3;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    step();
    redirect_i = 1'b0;
    sb.delete();
    wait_addr(32'h208, 40, "reach_208");
    chk1("pre_rst_valid", instr_valid_o, 1'b1);
    chk("pre_rst_head", instr_pc_o, 32'h200);
    rst_i     = 1'b0;
    mem_auto  = 1'b0;
    mem_ack_i = 1'b0;
    step();
    rst_i      = 1'b1;
    mem_ack_i  = 1'b1;
    mem_data_i = 32'hDEAD_BEEF;
    chk1("post_rst_req", mem_req_o, 1'b0);
    chk1("post_rst_valid", instr_valid_o, 1'b0);
    chk("post_rst_addr", mem_addr_o, 32'h0);
    step();
    mem_ack_i = 1'b0;
    chk1("late_ack_req", mem_req_o, 1'b1);
    chk("late_ack_addr", mem_addr_o, 32'h0);
    chk1("late_ack_ignored", instr_valid_o, 1'b0);
    mem_lat       = 0;
    mem_auto      = 1'b1;
    instr_ready_i = 1'b1;
    push_exp(32'h0, 16);
    c0 = n_consumed;
    for (int i = 0; i < 6; i++) step();
    chk("restart_count", 32'(n_consumed - c0), 32'd4);

    instr_ready_i = 1'b0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
